// File: rtl/pwm_pkg.sv
// Shared types and defaults for the pulse sequencer.
// Latency: n/a (types only).  Backpressure: n/a.
// The channel config struct is sized from CW, so CW is fixed here rather than per instance.
package pwm_pkg;

    localparam int CW      = 13;
    localparam int DEF_NCH = 4;
    localparam int DEF_DIV = 25;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } run_state_t;

    typedef struct packed {
        logic [CW-1:0] offset;
        logic [CW-1:0] width;
    } chan_cfg_t;

    // A frame shorter than two ticks cannot hold both edges of a pulse.
    function automatic logic [CW-1:0] clamp_period(input logic [CW-1:0] p);
        return (p < CW'(2)) ? CW'(2) : p;
    endfunction

endpackage

// File: rtl/pwm_sequencer_if.sv
// Channel configuration write port for the pulse sequencer.
// Latency: a write is taken on the edge where cfg_valid and cfg_ready are both high.
// Backpressure: cfg_ready drops while the addressed channel still holds an uncommitted write.
interface pwm_sequencer_if
    import pwm_pkg::*;
#(
    parameter int NCH = DEF_NCH
);
    localparam int CHW = (NCH > 1) ? $clog2(NCH) : 1;

    logic           cfg_valid;
    logic           cfg_ready;
    logic [CHW-1:0] cfg_ch;
    logic [CW-1:0]  cfg_offset;
    logic [CW-1:0]  cfg_width;

    modport master (
        output cfg_valid, cfg_ch, cfg_offset, cfg_width,
        input  cfg_ready
    );

    modport slave (
        input  cfg_valid, cfg_ch, cfg_offset, cfg_width,
        output cfg_ready
    );

endinterface

// File: rtl/pwm_channel.sv
// One sequencer channel: shadow/active config, pulse compare and edge strobes.
// Latency: signal follows the frame counter by one cycle; strobes register with signal.
// Backpressure: pending stays high from an accepted write until the next commit.
module pwm_channel
    import pwm_pkg::*;
(
    input  logic          clk,
    input  logic          reset,
    input  logic          en,
    input  logic          busy,
    input  logic          commit,
    input  logic          end_run,
    input  logic          wr,
    input  chan_cfg_t     wr_cfg,
    input  logic [CW-1:0] cnt,
    output logic          pending,
    output logic          signal,
    output logic          pwm_set,
    output logic          pwm_reset
);

    chan_cfg_t     shadow;
    chan_cfg_t     active;
    logic [CW:0]   pulse_end;
    logic          hit;
    logic          sig_n;

    // One extra bit keeps offset+width from wrapping back into the frame.
    assign pulse_end = {1'b0, active.offset} + {1'b0, active.width};
    assign hit       = busy && (cnt >= active.offset) && ({1'b0, cnt} < pulse_end);
    assign sig_n     = hit && !end_run;

    // A write landing on a commit edge stays pending for the following boundary.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            shadow  <= '0;
            active  <= '0;
            pending <= 1'b0;
        end else begin
            if (commit) begin
                active  <= shadow;
                pending <= 1'b0;
            end
            if (wr) begin
                shadow  <= wr_cfg;
                pending <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            signal    <= 1'b0;
            pwm_set   <= 1'b0;
            pwm_reset <= 1'b0;
        end else if (en) begin
            signal    <= sig_n;
            pwm_set   <= sig_n && !signal;
            pwm_reset <= !sig_n && signal;
        end else begin
            pwm_set   <= 1'b0;
            pwm_reset <= 1'b0;
        end
    end

endmodule

// File: rtl/upwardCounter.sv
// Free-running up counter that wraps to zero after MAX; clr has priority over inc.
// Latency: count changes on the edge where inc or clr is sampled high.
// Backpressure: none; holds its value while inc is low.
module upwardCounter #(
    parameter int W   = 4,
    parameter int MAX = 15
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] count
);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (inc) begin
            count <= (count == W'(MAX)) ? '0 : count + W'(1);
        end
    end

endmodule

// File: rtl/pwm_sequencer.sv
// Multi-channel pulse sequencer: prescaled tick drives a frame counter, one pulse per channel per frame.
// Latency: busy one edge after start; signal/strobes one cycle behind cnt.
// Backpressure: per-channel cfg_ready low while that channel has a write awaiting a frame boundary.
module pwm_sequencer
    import pwm_pkg::*;
#(
    parameter int NCH = DEF_NCH,
    parameter int DIV = DEF_DIV
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           en,
    input  logic           start,
    input  logic           stop,
    input  logic           oneshot,
    input  logic [CW-1:0]  period,
    pwm_sequencer_if.slave cfg,
    output logic           tick,
    output logic [CW-1:0]  cnt,
    output logic           busy,
    output logic [NCH-1:0] signal,
    output logic [NCH-1:0] pwm_set,
    output logic [NCH-1:0] pwm_reset
);

    localparam int CHW = (NCH > 1) ? $clog2(NCH) : 1;
    localparam int PW  = (DIV > 1) ? $clog2(DIV) : 1;

    run_state_t       state, state_n;
    logic [CW-1:0]    cnt_n;
    logic [CW-1:0]    p_a, p_a_n;
    logic             os_a, os_a_n;
    logic             stop_req, stop_req_n;
    logic             commit;
    logic             end_run;
    logic             pre_clr;
    logic [PW-1:0]    pre_cnt;
    logic [NCH-1:0]   pending;
    logic [2**CHW-1:0] pend_ext;
    logic             cfg_acc;
    chan_cfg_t        wr_cfg;

    upwardCounter #(
        .W   (PW),
        .MAX (DIV - 1)
    ) u_prescale (
        .clk   (clk),
        .reset (reset),
        .clr   (pre_clr),
        .inc   (busy & en),
        .count (pre_cnt)
    );

    assign busy = (state == RUN);
    assign tick = busy && en && (pre_cnt == PW'(DIV - 1));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            cnt      <= '0;
            p_a      <= '0;
            os_a     <= 1'b0;
            stop_req <= 1'b0;
        end else begin
            state    <= state_n;
            cnt      <= cnt_n;
            p_a      <= p_a_n;
            os_a     <= os_a_n;
            stop_req <= stop_req_n;
        end
    end

    // en low freezes the whole run; only config writes keep flowing.
    always_comb begin
        state_n    = state;
        cnt_n      = cnt;
        p_a_n      = p_a;
        os_a_n     = os_a;
        stop_req_n = stop_req;
        commit     = 1'b0;
        end_run    = 1'b0;
        pre_clr    = 1'b0;
        if (en) begin
            case (state)
                IDLE: begin
                    if (start) begin
                        state_n    = RUN;
                        cnt_n      = '0;
                        p_a_n      = clamp_period(period);
                        os_a_n     = oneshot;
                        stop_req_n = stop;
                        commit     = 1'b1;
                        pre_clr    = 1'b1;
                    end
                end
                RUN: begin
                    if (stop) begin
                        stop_req_n = 1'b1;
                    end
                    if (tick) begin
                        if (cnt == p_a - CW'(1)) begin
                            cnt_n  = '0;
                            p_a_n  = clamp_period(period);
                            commit = 1'b1;
                            if (os_a || stop_req || stop) begin
                                state_n    = IDLE;
                                stop_req_n = 1'b0;
                                end_run    = 1'b1;
                            end
                        end else begin
                            cnt_n = cnt + CW'(1);
                        end
                    end
                end
                default: state_n = IDLE;
            endcase
        end
    end

    // Channel indices beyond NCH read as never pending, so their writes are taken and dropped.
    always_comb begin
        pend_ext              = '0;
        pend_ext[NCH-1:0]     = pending;
    end

    assign cfg.cfg_ready = !pend_ext[cfg.cfg_ch];
    assign cfg_acc       = cfg.cfg_valid && cfg.cfg_ready;
    assign wr_cfg        = '{offset: cfg.cfg_offset, width: cfg.cfg_width};

    for (genvar i = 0; i < NCH; i++) begin : g_ch
        pwm_channel u_ch (
            .clk       (clk),
            .reset     (reset),
            .en        (en),
            .busy      (busy),
            .commit    (commit),
            .end_run   (end_run),
            .wr        (cfg_acc && (cfg.cfg_ch == CHW'(i))),
            .wr_cfg    (wr_cfg),
            .cnt       (cnt),
            .pending   (pending[i]),
            .signal    (signal[i]),
            .pwm_set   (pwm_set[i]),
            .pwm_reset (pwm_reset[i])
        );
    end

endmodule

// File: tb/tb_pwm_sequencer.sv
// Bench for pwm_sequencer: cycle scoreboard against a behavioural model plus
// a table of single-frame pulse vectors and hand-written corner sequences.
module tb_pwm_sequencer;
    import pwm_pkg::*;

    localparam int NCH  = 4;
    localparam int DIVT = 4;
    localparam int CHW  = $clog2(NCH);

    logic           clk = 1'b0;
    logic           reset = 1'b0;
    logic           en = 1'b0;
    logic           start = 1'b0;
    logic           stop = 1'b0;
    logic           oneshot = 1'b0;
    logic [CW-1:0]  period = '0;
    logic           tick;
    logic [CW-1:0]  cnt;
    logic           busy;
    logic [NCH-1:0] signal, pwm_set, pwm_reset;

    pwm_sequencer_if #(.NCH(NCH)) cfg_if ();

    pwm_sequencer #(.NCH(NCH), .DIV(DIVT)) dut (
        .clk       (clk),
        .reset     (reset),
        .en        (en),
        .start     (start),
        .stop      (stop),
        .oneshot   (oneshot),
        .period    (period),
        .cfg       (cfg_if),
        .tick      (tick),
        .cnt       (cnt),
        .busy      (busy),
        .signal    (signal),
        .pwm_set   (pwm_set),
        .pwm_reset (pwm_reset)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic           tick;
        logic [CW-1:0]  cnt;
        logic           busy;
        logic [NCH-1:0] sig;
        logic [NCH-1:0] set;
        logic [NCH-1:0] rst;
        logic           rdy;
    } sb_t;

    typedef struct {
        int period;
        int off;
        int wid;
        int exp_busy;
        int exp_high;
        int exp_set;
        int exp_rst;
    } vec_t;

    sb_t   sb_q[$];
    int    n_vec = 0;
    int    n_err = 0;
    int    nb, nh, ns, nr;
    vec_t  tbl[8];

    // Behavioural reference state
    int           m_pre, m_cnt, m_pa;
    bit           m_busy, m_os, m_sr;
    bit [NCH-1:0] m_sig, m_set, m_rst, m_pend;
    int           m_sh_off[NCH], m_sh_wid[NCH], m_ac_off[NCH], m_ac_wid[NCH];

    function automatic void model_reset();
        m_pre = 0; m_cnt = 0; m_pa = 0;
        m_busy = 0; m_os = 0; m_sr = 0;
        m_sig = '0; m_set = '0; m_rst = '0; m_pend = '0;
        for (int i = 0; i < NCH; i++) begin
            m_sh_off[i] = 0; m_sh_wid[i] = 0; m_ac_off[i] = 0; m_ac_wid[i] = 0;
        end
    endfunction

    function automatic void model_commit();
        for (int i = 0; i < NCH; i++) begin
            if (m_pend[i]) begin
                m_ac_off[i] = m_sh_off[i];
                m_ac_wid[i] = m_sh_wid[i];
                m_pend[i]   = 1'b0;
            end
        end
    endfunction

    function automatic int clamp2(input int p);
        return (p < 2) ? 2 : p;
    endfunction

    // Advance the model by one clock edge using the inputs currently driven.
    function automatic void model_edge();
        int ch;
        bit acc, tk, bnd, fin, hit;
        ch  = int'(cfg_if.cfg_ch);
        acc = cfg_if.cfg_valid && !(ch < NCH && m_pend[ch]);
        tk  = m_busy && en && (m_pre == DIVT - 1);
        bnd = tk && (m_cnt == m_pa - 1);
        fin = bnd && (m_os || m_sr || stop);
        if (en) begin
            for (int i = 0; i < NCH; i++) begin
                hit = m_busy && (m_ac_wid[i] != 0) && (m_cnt >= m_ac_off[i]) &&
                      (m_cnt < m_ac_off[i] + m_ac_wid[i]);
                if (fin) hit = 0;
                m_set[i] = hit && !m_sig[i];
                m_rst[i] = !hit && m_sig[i];
                m_sig[i] = hit;
            end
            if (!m_busy) begin
                if (start) begin
                    m_busy = 1; m_cnt = 0; m_pre = 0;
                    m_pa = clamp2(int'(period)); m_os = oneshot; m_sr = stop;
                    model_commit();
                end
            end else begin
                if (stop) m_sr = 1;
                m_pre = tk ? 0 : m_pre + 1;
                if (tk) begin
                    if (bnd) begin
                        m_cnt = 0;
                        m_pa  = clamp2(int'(period));
                        model_commit();
                        if (fin) begin
                            m_busy = 0;
                            m_sr   = 0;
                        end
                    end else begin
                        m_cnt = m_cnt + 1;
                    end
                end
            end
        end else begin
            m_set = '0;
            m_rst = '0;
        end
        if (acc && ch < NCH) begin
            m_sh_off[ch] = int'(cfg_if.cfg_offset);
            m_sh_wid[ch] = int'(cfg_if.cfg_width);
            m_pend[ch]   = 1'b1;
        end
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic check_out();
        sb_t e;
        n_vec++;
        if (sb_q.size() == 0) begin
            n_err++;
            $display("FAIL scoreboard: queue empty at t=%0t", $time);
            return;
        end
        e = sb_q.pop_front();
        if (tick !== e.tick || cnt !== e.cnt || busy !== e.busy || signal !== e.sig ||
            pwm_set !== e.set || pwm_reset !== e.rst || cfg_if.cfg_ready !== e.rdy) begin
            n_err++;
            $display("FAIL cycle t=%0t got tick=%b cnt=%0d busy=%b sig=%b set=%b rst=%b rdy=%b want tick=%b cnt=%0d busy=%b sig=%b set=%b rst=%b rdy=%b",
                     $time, tick, cnt, busy, signal, pwm_set, pwm_reset, cfg_if.cfg_ready,
                     e.tick, e.cnt, e.busy, e.sig, e.set, e.rst, e.rdy);
        end
    endtask

    task automatic step();
        sb_t e;
        int  ch;
        model_edge();
        ch    = int'(cfg_if.cfg_ch);
        e.tick = m_busy && en && (m_pre == DIVT - 1);
        e.cnt  = CW'(m_cnt);
        e.busy = m_busy;
        e.sig  = m_sig;
        e.set  = m_set;
        e.rst  = m_rst;
        e.rdy  = !(ch < NCH && m_pend[ch]);
        sb_q.push_back(e);
        @(posedge clk);
        #1;
        check_out();
    endtask

    task automatic write_cfg(input int ch, input int off, input int wid);
        cfg_if.cfg_valid  = 1'b1;
        cfg_if.cfg_ch     = CHW'(ch);
        cfg_if.cfg_offset = CW'(off);
        cfg_if.cfg_width  = CW'(wid);
        step();
        cfg_if.cfg_valid  = 1'b0;
    endtask

    // what: 0 = pwm_set[0], 1 = pwm_reset[0], other = busy low
    task automatic run_until(input int what, input int bound, input string name);
        bit hit;
        hit = 0;
        for (int i = 0; i < bound && !hit; i++) begin
            step();
            case (what)
                0:       hit = pwm_set[0];
                1:       hit = pwm_reset[0];
                default: hit = !busy;
            endcase
        end
        if (!hit) chk({name, " timeout"}, 0, 1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        tbl[0] = '{10, 2, 3,    40, 12, 1, 1};
        tbl[1] = '{ 8, 6, 5,    32,  7, 1, 1};
        tbl[2] = '{ 0, 0, 1,     8,  4, 1, 1};
        tbl[3] = '{ 6, 1, 0,    24,  0, 0, 0};
        tbl[4] = '{ 5, 5, 3,    20,  0, 0, 0};
        tbl[5] = '{ 4, 0, 4,    16, 15, 1, 1};
        tbl[6] = '{ 3, 1, 8191, 12,  7, 1, 1};
        tbl[7] = '{ 0, 1, 1,     8,  3, 1, 1};

        cfg_if.cfg_valid  = 1'b0;
        cfg_if.cfg_ch     = '0;
        cfg_if.cfg_offset = '0;
        cfg_if.cfg_width  = '0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        chk("reset cnt",  int'(cnt), 0);
        chk("reset busy", int'(busy), 0);
        chk("reset tick", int'(tick), 0);
        chk("reset sig",  int'(signal), 0);
        chk("reset set",  int'(pwm_set), 0);
        chk("reset rst",  int'(pwm_reset), 0);
        chk("reset rdy",  int'(cfg_if.cfg_ready), 1);
        reset = 1'b1;
        en    = 1'b1;
        step();

        // Single-frame pulse table
        for (int v = 0; v < 8; v++) begin
            write_cfg(0, tbl[v].off, tbl[v].wid);
            period  = CW'(tbl[v].period);
            oneshot = 1'b1;
            start   = 1'b1;
            step();
            start = 1'b0;
            nb = 0; nh = 0; ns = 0; nr = 0;
            for (int i = 0; i < 200; i++) begin
                nb += int'(busy); nh += int'(signal[0]);
                ns += int'(pwm_set[0]); nr += int'(pwm_reset[0]);
                if (!busy) break;
                step();
            end
            step();
            nh += int'(signal[0]); ns += int'(pwm_set[0]); nr += int'(pwm_reset[0]);
            chk($sformatf("vec%0d busy cycles", v), nb, tbl[v].exp_busy);
            chk($sformatf("vec%0d high cycles", v), nh, tbl[v].exp_high);
            chk($sformatf("vec%0d set count", v),   ns, tbl[v].exp_set);
            chk($sformatf("vec%0d reset count", v), nr, tbl[v].exp_rst);
        end

        // Mid-frame rewrite lands at the next boundary; second write is held off
        oneshot = 1'b0;
        period  = CW'(10);
        write_cfg(0, 2, 3);
        start = 1'b1; step(); start = 1'b0;
        run_until(0, 100, "A set");   chk("A set cnt", int'(cnt), 2);
        run_until(1, 100, "A rst");   chk("A rst cnt", int'(cnt), 5);
        write_cfg(0, 5, 2);
        chk("A rdy while pending", int'(cfg_if.cfg_ready), 0);
        write_cfg(0, 7, 1);
        run_until(0, 100, "A set2");  chk("A set2 cnt", int'(cnt), 5);
        run_until(1, 100, "A rst2");  chk("A rst2 cnt", int'(cnt), 7);
        stop = 1'b1; step(); stop = 1'b0;
        run_until(2, 100, "A idle");

        // Full-width pulse holds across wraps with no strobes
        write_cfg(0, 0, 4);
        period = CW'(4);
        start = 1'b1; step(); start = 1'b0;
        ns = 0; nr = 0;
        for (int i = 0; i < 48; i++) begin
            step();
            ns += int'(pwm_set[0]); nr += int'(pwm_reset[0]);
        end
        chk("B wrap sets", ns, 1);
        chk("B wrap resets", nr, 0);
        stop = 1'b1; step(); stop = 1'b0;
        run_until(1, 100, "B end rst");
        chk("B busy at final reset", int'(busy), 0);
        step();

        // Enable freeze mid-pulse
        period = CW'(10);
        write_cfg(0, 2, 3);
        start = 1'b1; step(); start = 1'b0;
        run_until(0, 100, "C set");
        step();
        en = 1'b0;
        ns = 0; nr = 0; nh = 0;
        for (int i = 0; i < 7; i++) begin
            step();
            ns += int'(pwm_set[0]); nr += int'(pwm_reset[0]); nh += int'(signal[0]);
        end
        en = 1'b1;
        chk("C frozen strobes", ns + nr, 0);
        chk("C frozen high", nh, 7);
        run_until(1, 100, "C rst");   chk("C rst cnt", int'(cnt), 5);
        stop = 1'b1; step(); stop = 1'b0;
        run_until(2, 100, "C idle");

        // start and stop together run exactly one frame
        period = CW'(5);
        start = 1'b1; stop = 1'b1; step(); start = 1'b0; stop = 1'b0;
        nb = 0;
        for (int i = 0; i < 100; i++) begin
            nb += int'(busy);
            if (!busy) break;
            step();
        end
        chk("D one frame busy", nb, 20);

        // Asynchronous reset mid-pulse
        period = CW'(10);
        write_cfg(0, 2, 3);
        start = 1'b1; step(); start = 1'b0;
        run_until(0, 100, "E set");
        step();
        reset = 1'b0;
        #1;
        chk("E cnt",  int'(cnt), 0);
        chk("E busy", int'(busy), 0);
        chk("E tick", int'(tick), 0);
        chk("E sig",  int'(signal), 0);
        chk("E strobes", int'(pwm_set | pwm_reset), 0);
        chk("E rdy",  int'(cfg_if.cfg_ready), 1);
        model_reset();
        @(posedge clk);
        #1;
        reset   = 1'b1;
        oneshot = 1'b1;
        start = 1'b1; step(); start = 1'b0;
        chk("E restart cnt", int'(cnt), 0);
        nb = 0; nh = 0;
        for (int i = 0; i < 100; i++) begin
            nb += int'(busy); nh += int'(signal[0]);
            if (!busy) break;
            step();
        end
        chk("E cleared cfg high", nh, 0);
        chk("E restart busy", nb, 40);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
